// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit. Holds the FSM
//               state encoding, the RV64 load/store funct3 codes and helpers
//               for the access-size mask and illegal-funct3 decode.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WR    = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Byte-offset bits that lie below the access size (set bits must be 0
    // for an aligned access). funct3[1:0] encodes log2 of the size.
    function automatic logic [2:0] size_mask(input logic [2:0] funct3);
        logic [2:0] m;
        case (funct3[1:0])
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    // Stores only exist for B/H/W/D; loads have no encoding 111.
    function automatic logic is_bad_funct3(input logic store, input logic [2:0] funct3);
        return store ? funct3[2] : (funct3 == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Request/response and data_memory bus of the load/store unit.
//               slave  modport : seen by load_store_unit
//               master modport : seen by the requester / memory side
//               Signals: req_valid/ready/store/funct3/addr/wdata,
//               resp_valid/rdata/err, mem_write/read/address/write_data,
//               mem_read_data.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int ADDR_W = 6,
    parameter int XLEN   = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic [XLEN-1:0]   mem_write_data;
    logic [XLEN-1:0]   mem_read_data;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_write, mem_read, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_write, mem_read, mem_address, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/lsu_data_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_data_align
// Description : Combinational lane logic. Extracts and sign/zero-extends the
//               load lane at byte offset i_off, and merges the store lane
//               into the read doubleword for sub-doubleword stores.
//   i_dword      : doubleword read from memory
//   i_off        : byte offset of the lane (already aligned as required)
//   i_funct3     : access size/sign
//   i_wdata      : store data, low bytes used
//   o_load_data  : extended load result
//   o_store_data : doubleword with the store lane replaced
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_data_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  wire logic [XLEN-1:0] i_dword,
    input  wire logic [2:0]      i_off,
    input  wire logic [2:0]      i_funct3,
    input  wire logic [XLEN-1:0] i_wdata,
    output logic      [XLEN-1:0] o_load_data,
    output logic      [XLEN-1:0] o_store_data
);
    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_lane_mask;

    assign w_shamt = {i_off, 3'b000};
    assign w_lane  = i_dword >> w_shamt;

    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_B:    o_load_data = {{(XLEN-8){w_lane[7]}},   w_lane[7:0]};
            F3_H:    o_load_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            F3_W:    o_load_data = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
            F3_D:    o_load_data = w_lane;
            F3_BU:   o_load_data = {{(XLEN-8){1'b0}},  w_lane[7:0]};
            F3_HU:   o_load_data = {{(XLEN-16){1'b0}}, w_lane[15:0]};
            F3_WU:   o_load_data = {{(XLEN-32){1'b0}}, w_lane[31:0]};
            default: o_load_data = '0;
        endcase
    end

    always_comb begin
        w_lane_mask = '1;
        case (i_funct3[1:0])
            2'd0:    w_lane_mask = {{(XLEN-8){1'b0}},  8'hFF};
            2'd1:    w_lane_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            2'd2:    w_lane_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
            default: w_lane_mask = '1;
        endcase
    end

    assign o_store_data = (i_dword & ~(w_lane_mask << w_shamt))
                        | ((i_wdata & w_lane_mask) << w_shamt);

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV64 memory-stage load/store unit in front of data_memory.
//               One request at a time; loads read, extract and extend a lane;
//               SB/SH/SW do read-modify-write; SD writes directly.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : load_store_unit_if.slave (request, response, memory bus)
//   Macro MISALIGN_TRAP_EN: when defined, misaligned accesses respond with
//   resp_err and no memory access; otherwise the address is aligned down.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int XLEN   = 64
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    load_store_unit_if.slave  bus
);
    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;

    logic              r_store;
    logic [2:0]        r_funct3;
    logic [2:0]        r_off;
    logic [ADDR_W-1:0] r_idx;
    logic [XLEN-1:0]   r_wdata;

    logic              r_req_ready;
    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_resp_err;
    logic              r_mem_write;
    logic              r_mem_read;
    logic [ADDR_W-1:0] r_mem_address;
    logic [XLEN-1:0]   r_mem_write_data;

    logic              w_accept;
    logic [2:0]        w_req_mask;
    logic [2:0]        w_req_off;
    logic              w_req_err;
    logic              w_req_sd;
    logic [ADDR_W-1:0] w_idx;
    logic              w_mem_active_nxt;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN-1:0]   w_store_data;

    assign w_accept   = (r_state == ST_IDLE) && bus.req_valid;
    assign w_req_mask = size_mask(bus.req_funct3);
    assign w_req_sd   = bus.req_store && (bus.req_funct3 == F3_D);

`ifdef MISALIGN_TRAP_EN
    assign w_req_off = bus.req_addr[2:0];
    assign w_req_err = is_bad_funct3(bus.req_store, bus.req_funct3)
                     || (|(bus.req_addr[2:0] & w_req_mask));
`else
    assign w_req_off = bus.req_addr[2:0] & ~w_req_mask;
    assign w_req_err = is_bad_funct3(bus.req_store, bus.req_funct3);
`endif

    // The address must be on the bus in the first RD/WR cycle, i.e. before
    // the request latch has been loaded.
    assign w_idx = (r_state == ST_IDLE) ? bus.req_addr[ADDR_W+2:3] : r_idx;

    lsu_data_align #(.XLEN(XLEN)) u_align (
        .i_dword      (bus.mem_read_data),
        .i_off        (r_off),
        .i_funct3     (r_funct3),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_data (w_store_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (w_req_err)     w_state_nxt = ST_RESP;
                    else if (w_req_sd) w_state_nxt = ST_WR;
                    else               w_state_nxt = ST_RD;
                end
            end
            ST_RD:    w_state_nxt = ST_RWAIT;
            ST_RWAIT: w_state_nxt = r_store ? ST_WR : ST_RESP;
            ST_WR:    w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_mem_active_nxt = (w_state_nxt == ST_RD) || (w_state_nxt == ST_RWAIT)
                            || (w_state_nxt == ST_WR);

    // Request latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_off    <= 3'b000;
            r_idx    <= '0;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_store  <= bus.req_store;
            r_funct3 <= bus.req_funct3;
            r_off    <= w_req_off;
            r_idx    <= bus.req_addr[ADDR_W+2:3];
            r_wdata  <= bus.req_wdata;
        end
    end

    // Outputs are decoded from the next state so they line up with it.
    // Write data comes straight from the request for SD and from the
    // merged read doubleword (captured at the end of RWAIT) otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_rdata     <= '0;
            r_resp_err       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
        end else begin
            r_req_ready      <= (w_state_nxt == ST_IDLE);
            r_mem_read       <= (w_state_nxt == ST_RD) || (w_state_nxt == ST_RWAIT);
            r_mem_write      <= (w_state_nxt == ST_WR);
            r_mem_address    <= w_mem_active_nxt ? w_idx : '0;
            r_mem_write_data <= (w_state_nxt != ST_WR) ? '0 :
                                (r_state == ST_IDLE)   ? bus.req_wdata : w_store_data;
            r_resp_valid     <= (w_state_nxt == ST_RESP);
            // Only the error path jumps from IDLE directly to RESP.
            r_resp_err       <= (w_state_nxt == ST_RESP) && (r_state == ST_IDLE);
            r_resp_rdata     <= ((w_state_nxt == ST_RESP) && (r_state == ST_RWAIT) && !r_store)
                                ? w_load_data : '0;
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_rdata     = r_resp_rdata;
    assign bus.resp_err       = r_resp_err;
    assign bus.mem_write      = r_mem_write;
    assign bus.mem_read       = r_mem_read;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_write_data = r_mem_write_data;

endmodule
`default_nettype wire
